// File: rtl/crcu_apb_pkg.sv
// ============================================================================
// crcu_apb_pkg : shared APB state encoding and default bus widths
// Rev 1.0
// ============================================================================
`default_nettype none

package crcu_apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/crcu_apb_wdog.sv
// ============================================================================
// crcu_apb_wdog : ACCESS wait-cycle watchdog (built only with CRCU_APB_TIMEOUT_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

`ifdef CRCU_APB_TIMEOUT_EN
module crcu_apb_wdog #(
  parameter int LIMIT = 16
) (
  input  logic PCLK,
  input  logic PRESETN,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  // Fires in the cycle that would bring the count to LIMIT.
  assign expired = count_en && (cnt == CNT_W'(LIMIT - 1));

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      cnt <= '0;
    end else if (clear || expired) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/crcu_apb_master.sv
// ============================================================================
// crcu_apb_master : single-outstanding APB requester with command/response side
// Optional ACCESS timeout enabled by defining CRCU_APB_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module crcu_apb_master
  import crcu_apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] PRDATA
);

  state_t state;
  state_t state_nxt;
  logic   live;
  logic   accept;
  logic   misaligned;
  logic   timeout;

  // live holds cmd_ready low while reset is asserted and until the first edge after.
  assign cmd_ready  = live && (state == IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign misaligned = (cmd_addr[1:0] != 2'b00);

`ifdef CRCU_APB_TIMEOUT_EN
  crcu_apb_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .PCLK     (PCLK),
    .PRESETN  (PRESETN),
    .count_en ((state == ACCESS) && !PREADY),
    .clear    (state != ACCESS),
    .expired  (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !misaligned) state_nxt = SETUP;
      end
      SETUP: begin
        PSEL      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state     <= IDLE;
      live      <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      live      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      if (accept) begin
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        PWDATA <= cmd_wdata;
      end
      if (accept && misaligned) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
      end else if ((state == ACCESS) && PREADY) begin
        rsp_valid <= 1'b1;
        rsp_err   <= PSLVERR;
        rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
      end else if (timeout) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/crcu_apb_master.md
CRCU_APB_MASTER -- requirements
Module: crcu_apb_master

Interface
REQ-001 The block SHALL use one clock, PCLK; reset SHALL be PRESETN, asynchronous and active-low.
REQ-002 Parameter ADDR_W, default 32, SHALL set the APB address width.
REQ-003 Parameter DATA_W, default 32, SHALL set the APB data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum number of ACCESS wait cycles (used only with the timeout feature).
REQ-005 Ports, one per line (name, direction, width, meaning):
 PCLK  in  1  APB clock
 PRESETN  in  1  async active-low reset
 cmd_valid  in  1  command request
 cmd_ready  out  1  command accepted this cycle when high with cmd_valid
 cmd_write  in  1  1 = write, 0 = read
 cmd_addr  in  ADDR_W  byte address
 cmd_wdata  in  DATA_W  write data
 rsp_valid  out  1  one-cycle response strobe
 rsp_rdata  out  DATA_W  read data (0 for writes and errors)
 rsp_err  out  1  PSLVERR, misalignment or timeout
 PSEL  out  1  APB select
 PENABLE  out  1  APB enable
 PADDR  out  ADDR_W  APB address
 PWRITE  out  1  APB direction
 PWDATA  out  DATA_W  APB write data
 PREADY  in  1  completer ready
 PSLVERR  in  1  completer error
 PRDATA  in  DATA_W  completer read data

Function
REQ-006 The FSM SHALL have the states IDLE, SETUP and ACCESS; only one transfer SHALL be outstanding at a time.
REQ-007 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready, the block SHALL latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, and move to SETUP.
REQ-008 In SETUP, PSEL SHALL be 1 and PENABLE 0 for exactly one cycle; the FSM SHALL then move to ACCESS.
REQ-009 In ACCESS, PSEL=1 and PENABLE=1 SHALL hold until PREADY is sampled 1; PADDR, PWRITE and PWDATA SHALL stay stable from SETUP through the end of ACCESS.
REQ-010 On PREADY=1 in ACCESS, the block SHALL return to IDLE; in the next cycle it SHALL assert rsp_valid for exactly one cycle, with rsp_err=PSLVERR and rsp_rdata=PRDATA (read without error) or 0 (write or error).
REQ-011 Latency SHALL be fixed: accept at edge k, SETUP in cycle k+1, ACCESS in cycle k+2, rsp_valid and cmd_ready=1 in cycle k+3 when PREADY=1 with no wait.
REQ-012 A command with cmd_addr[1:0]!=0 SHALL be accepted without any APB transfer (PSEL stays 0); rsp_valid SHALL follow in the next cycle with rsp_err=1 and rsp_rdata=0.
REQ-013 In IDLE, PSEL and PENABLE SHALL be 0; PADDR, PWRITE and PWDATA SHALL hold their last values.
REQ-014 rsp_valid SHALL have no backpressure; the consumer always accepts it.

Reset
REQ-015 PRESETN low, including mid-transfer, SHALL immediately force IDLE, PSEL=0, PENABLE=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, PADDR=0, PWDATA=0, PWRITE=0 and cmd_ready=0; cmd_ready SHALL rise in the first cycle after PRESETN deasserts.
REQ-016 A transfer interrupted by reset SHALL produce no response.

Configuration
REQ-017 With CRCU_APB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles with PREADY=0; when it reaches TIMEOUT_CYCLES, the block SHALL drive PSEL=PENABLE=0, return to IDLE, and pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-018 Without CRCU_APB_TIMEOUT_EN, ACCESS SHALL wait indefinitely for PREADY and TIMEOUT_CYCLES SHALL have no effect.

Structure
REQ-019 Package crcu_apb_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS) and the default ADDR_W/DATA_W constants, shared with the completer side.
REQ-020 The timeout counter SHALL be sub-module crcu_apb_wdog, instantiated only under CRCU_APB_TIMEOUT_EN.

Verification
REQ-021 Write 0x0000_0010 <- 0xDEAD_BEEF with PREADY=1 -> SETUP then ACCESS observed; rsp_valid at k+3 with rsp_err=0 and rsp_rdata=0.
REQ-022 Read 0x0000_0004 with PREADY low for 3 ACCESS cycles and PRDATA=0x1234_5678 -> PADDR stable for 5 cycles; rsp_rdata=0x1234_5678 at k+6.
REQ-023 Read with PSLVERR=1 on the PREADY cycle -> rsp_err=1 and rsp_rdata=0.
REQ-024 cmd_addr=0x0000_0006 -> PSEL never rises; rsp_valid with rsp_err=1 one cycle after accept.
REQ-025 PRESETN pulsed low during ACCESS -> PSEL/PENABLE go 0 asynchronously with no rsp_valid; a following write completes normally.
REQ-026 With CRCU_APB_TIMEOUT_EN defined and PREADY tied 0 -> after 16 ACCESS cycles, PSEL drops and rsp_err=1; without the macro, PSEL is still high after 100 cycles.
